// File: rtl/de10_timer_avalon_master_if.sv
// rtl/de10_timer_avalon_master_if.sv - Avalon-MM link between the timer initiator and the interval-timer s1 port
interface de10_timer_avalon_master_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [15:0] writedata;
    logic [15:0] readdata;

    modport master (output address, chipselect, write_n, writedata, input readdata);
    modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/de10_timer_avalon_master.sv
// rtl/de10_timer_avalon_master.sv - command-driven Avalon-MM initiator for the interval-timer slave
module de10_timer_avalon_master #(
    parameter bit AUTO_ACK = 1'b1,
    parameter int CNT_W    = 16
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [2:0]                 cmd_op,
    input  logic [31:0]                cmd_period,
    input  logic                       cmd_continuous,
    input  logic                       cmd_irq_en,
    de10_timer_avalon_master_if.master avm,
    input  logic                       timer_irq,
    output logic                       snap_valid,
    output logic [31:0]                snap_value,
    output logic                       cmd_err,
    output logic [CNT_W-1:0]           timeout_count
);
    localparam logic [2:0] OP_CONFIG   = 3'd0;
    localparam logic [2:0] OP_START    = 3'd1;
    localparam logic [2:0] OP_STOP     = 3'd2;
    localparam logic [2:0] OP_SNAPSHOT = 3'd3;
    localparam logic [2:0] OP_ACK      = 3'd4;

    typedef enum logic [3:0] {
        S_IDLE, S_CFG_PL, S_CFG_PH, S_CFG_CTL, S_START_W, S_STOP_W,
        S_SNAP_W, S_SNAP_RL, S_SNAP_RH, S_SNAP_CAP, S_ACK_W
    } state_t;

    state_t      state, state_nx;
    logic [31:0] period_q, period_nx;
    logic        cont_q, cont_nx, ito_q, ito_nx;
    logic [15:0] snap_lo_q;
    logic        irq_svc, accept, err_nx;
    logic        cs_nx, wn_nx;
    logic [2:0]  addr_nx;
    logic [15:0] wd_nx;

    always_comb begin
        irq_svc   = AUTO_ACK && timer_irq;
        cmd_ready = (state == S_IDLE) && !irq_svc;
        accept    = cmd_valid && cmd_ready;
        period_nx = period_q;
        cont_nx   = cont_q;
        ito_nx    = ito_q;
        if (accept && cmd_op == OP_CONFIG) begin
            period_nx = cmd_period;
            cont_nx   = cmd_continuous;
            ito_nx    = cmd_irq_en;
        end
        err_nx   = accept && (cmd_op > OP_ACK);
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (irq_svc) begin
                    state_nx = S_ACK_W;
                end else if (accept) begin
                    case (cmd_op)
                        OP_CONFIG:   state_nx = S_CFG_PL;
                        OP_START:    state_nx = S_START_W;
                        OP_STOP:     state_nx = S_STOP_W;
                        OP_SNAPSHOT: state_nx = S_SNAP_W;
                        OP_ACK:      state_nx = S_ACK_W;
                        default:     state_nx = S_IDLE;
                    endcase
                end
            end
            S_CFG_PL:  state_nx = S_CFG_PH;
            S_CFG_PH:  state_nx = S_CFG_CTL;
            S_SNAP_W:  state_nx = S_SNAP_RL;
            S_SNAP_RL: state_nx = S_SNAP_RH;
            S_SNAP_RH: state_nx = S_SNAP_CAP;
            default:   state_nx = S_IDLE;
        endcase
    end

    // Bus outputs are registered from the next state so each state owns exactly its own bus cycle.
    always_comb begin
        cs_nx   = 1'b0;
        wn_nx   = 1'b1;
        addr_nx = 3'd0;
        wd_nx   = 16'h0000;
        case (state_nx)
            S_CFG_PL:  begin cs_nx = 1'b1; wn_nx = 1'b0; addr_nx = 3'd2; wd_nx = period_nx[15:0];  end
            S_CFG_PH:  begin cs_nx = 1'b1; wn_nx = 1'b0; addr_nx = 3'd3; wd_nx = period_nx[31:16]; end
            S_CFG_CTL: begin cs_nx = 1'b1; wn_nx = 1'b0; addr_nx = 3'd1; wd_nx = {14'h0, cont_nx, ito_nx}; end
            S_START_W: begin cs_nx = 1'b1; wn_nx = 1'b0; addr_nx = 3'd1; wd_nx = {13'h0, 1'b1, cont_nx, ito_nx}; end
            S_STOP_W:  begin cs_nx = 1'b1; wn_nx = 1'b0; addr_nx = 3'd1; wd_nx = {12'h0, 2'b10, cont_nx, ito_nx}; end
            S_SNAP_W:  begin cs_nx = 1'b1; wn_nx = 1'b0; addr_nx = 3'd4; end
            S_SNAP_RL: begin cs_nx = 1'b1; addr_nx = 3'd4; end
            S_SNAP_RH: begin cs_nx = 1'b1; addr_nx = 3'd5; end
            S_ACK_W:   begin cs_nx = 1'b1; wn_nx = 1'b0; addr_nx = 3'd0; end
            default:   ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nx;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            avm.chipselect <= 1'b0;
            avm.write_n    <= 1'b1;
            avm.address    <= 3'd0;
            avm.writedata  <= 16'h0000;
            period_q       <= 32'h0;
            cont_q         <= 1'b0;
            ito_q          <= 1'b0;
            snap_lo_q      <= 16'h0000;
            snap_valid     <= 1'b0;
            snap_value     <= 32'h0;
            cmd_err        <= 1'b0;
            timeout_count  <= '0;
        end else begin
            avm.chipselect <= cs_nx;
            avm.write_n    <= wn_nx;
            avm.address    <= addr_nx;
            avm.writedata  <= wd_nx;
            period_q       <= period_nx;
            cont_q         <= cont_nx;
            ito_q          <= ito_nx;
            cmd_err        <= err_nx;
            snap_valid     <= 1'b0;
            // readdata lags its read by one cycle: lo arrives in SNAP_RH, hi in SNAP_CAP.
            if (state == S_SNAP_RH) snap_lo_q <= avm.readdata;
            if (state == S_SNAP_CAP) begin
                snap_value <= {avm.readdata, snap_lo_q};
                snap_valid <= 1'b1;
            end
            if (state == S_ACK_W && timeout_count != {CNT_W{1'b1}})
                timeout_count <= timeout_count + CNT_W'(1);
        end
    end
endmodule
